// File: rtl/event_or_aggregator.sv
// N-input event aggregator: per-input bubble and edge/level conditioning feeding
// sticky pending bits, with an OR-reduced flag, a rising pulse and a priority index.
module event_or_aggregator #(
    parameter int          NR_OF_INPUTS = 8,
    parameter logic [31:0] BUBBLES_MASK = 32'h0,
    parameter logic [31:0] EDGE_MASK    = 32'h0,
    parameter int          INDEX_WIDTH  = 3
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic [NR_OF_INPUTS-1:0] Inputs,
    input  logic [NR_OF_INPUTS-1:0] Enable_mask,
    input  logic [NR_OF_INPUTS-1:0] Clear,
    output logic [NR_OF_INPUTS-1:0] Pending,
    output logic                    Result,
    output logic                    Result_pulse,
    output logic [INDEX_WIDTH-1:0]  First_index
);

    localparam logic [NR_OF_INPUTS-1:0] BUB_BITS  = BUBBLES_MASK[NR_OF_INPUTS-1:0];
    localparam logic [NR_OF_INPUTS-1:0] EDGE_BITS = EDGE_MASK[NR_OF_INPUTS-1:0];

    logic [NR_OF_INPUTS-1:0] real_in;
    logic [NR_OF_INPUTS-1:0] ev;
    logic [NR_OF_INPUTS-1:0] pending_next;
    logic [NR_OF_INPUTS-1:0] pending_reg;
    logic [NR_OF_INPUTS-1:0] prev_in_reg;
    logic [NR_OF_INPUTS-1:0] masked;
    logic                    result_reg;
    logic [INDEX_WIDTH-1:0]  first_index_next;

    generate
        for (genvar gi = 0; gi < NR_OF_INPUTS; gi++) begin : g_bit
            assign real_in[gi] = Inputs[gi] ^ BUB_BITS[gi];
            // Level inputs ignore the history flop; it folds away when EDGE_BITS[gi] = 0.
            assign ev[gi] = real_in[gi] & ~(prev_in_reg[gi] & EDGE_BITS[gi]);
            // A new event outranks a simultaneous clear so nothing is lost.
            assign pending_next[gi] = (ev[gi] & Enable_mask[gi])
                                    | (pending_reg[gi] & ~Clear[gi]);
        end
    endgenerate

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pending_reg <= '0;
            prev_in_reg <= '0;
            result_reg  <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            prev_in_reg <= real_in;
            result_reg  <= Result;
        end
    end

    assign masked = pending_reg & Enable_mask;

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        first_index_next = '0;
        for (int i = NR_OF_INPUTS - 1; i >= 0; i--) begin
            if (masked[i]) begin
                first_index_next = INDEX_WIDTH'(i);
            end
        end
    end

    assign Pending      = pending_reg;
    assign Result       = |masked;
    assign Result_pulse = Result & ~result_reg;
    assign First_index  = first_index_next;

endmodule
